// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and helpers for the alu_pipe datapath.
// Optional Carry output is enabled with the ALU_CARRY_FLAG_EN macro.
package alu_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ERRFLG = 3'd0,
    SUB    = 3'd1,
    PAR    = 3'd2,
    ADD    = 3'd3,
    XOR    = 3'd4,
    LSOR   = 3'd5,
    SHR    = 3'd6,
    NOP    = 3'd7
  } alu_op_e;

  // Only the add/subtract paths produce a meaningful carry/borrow.
  function automatic logic op_has_carry(input alu_op_e op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU core: result plus Zero/Parity flags (and Carry when
// ALU_CARRY_FLAG_EN is defined). Sits between the S1 and S2 registers.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  alu_op_e      i_op,
`ifdef ALU_CARRY_FLAG_EN
  output logic         o_carry,
`endif
  output logic [W-1:0] o_res,
  output logic         o_zero,
  output logic         o_parity
);

  localparam int SH_W = $clog2(W);
`ifdef ALU_CARRY_FLAG_EN
  localparam int SUM_W = W + 1;
`else
  localparam int SUM_W = W;
`endif

  logic [SUM_W-1:0] w_sum;
  logic [W-1:0]     w_res;

  always_comb begin
    w_sum = '0;
    w_res = '0;
    case (i_op)
      ERRFLG: w_res = {^i_a[W-2:0], i_a[W-2:0]};
      SUB: begin
        w_sum = SUM_W'(i_a) - SUM_W'(i_b);
        w_res = w_sum[W-1:0];
      end
      PAR:    w_res = {{(W-1){1'b0}}, ^(i_a & i_b)};
      ADD: begin
        w_sum = SUM_W'(i_a) + SUM_W'(i_b);
        w_res = w_sum[W-1:0];
      end
      XOR:    w_res = {1'b0, i_a[W-2:0] ^ i_b[W-2:0]};
      // Bit W-2 of A falls off; the pad bit stays clear.
      LSOR:   w_res = {1'b0, {i_a[W-3:0], 1'b0} | i_b[W-2:0]};
      SHR:    w_res = i_a >> i_b[SH_W-1:0];
      default: w_res = '0;
    endcase
  end

  assign o_res    = w_res;
  assign o_zero   = ~|w_res;
  assign o_parity = ^w_res;
`ifdef ALU_CARRY_FLAG_EN
  assign o_carry  = op_has_carry(i_op) & w_sum[SUM_W-1];
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with tag pass-through and a saturating
// retired-op counter. Define ALU_CARRY_FLAG_EN to add the Carry output.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [W-1:0]     InputA,
  input  logic [W-1:0]     InputB,
  input  alu_op_e          OP,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [W-1:0]     Out,
  output logic             Zero,
  output logic             Parity,
  output logic [TAG_W-1:0] OutTag,
`ifdef ALU_CARRY_FLAG_EN
  output logic             Carry,
`endif
  output logic [CNT_W-1:0] RetiredCnt
);

  typedef struct packed {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    alu_op_e          op;
    logic [TAG_W-1:0] tag;
  } alu_req_t;

  logic             w_s1_load, w_s2_load, w_accept;
  alu_req_t         r_req_p1;
  logic             r_vld_p1;
  logic [W-1:0]     w_res;
  logic             w_zero, w_parity;
  logic             r_vld_p2;
  logic [W-1:0]     r_out_p2;
  logic             r_zero_p2, r_parity_p2;
  logic [TAG_W-1:0] r_tag_p2;
  logic [CNT_W-1:0] r_cnt;
`ifdef ALU_CARRY_FLAG_EN
  logic             w_carry, r_carry_p2;
`endif

  assign w_s2_load = !r_vld_p2 || OutReady;
  assign w_s1_load = !r_vld_p1 || w_s2_load;
  assign w_accept  = InValid && w_s1_load;
  assign InReady   = w_s1_load;

  // Stage 1: capture the accepted request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_load) begin
      r_vld_p1 <= InValid;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_req_p1 <= '{a: InputA, b: InputB, op: OP, tag: InTag};
    end
  end

  alu_core #(.W(W)) u_core (
    .i_a      (r_req_p1.a),
    .i_b      (r_req_p1.b),
    .i_op     (r_req_p1.op),
`ifdef ALU_CARRY_FLAG_EN
    .o_carry  (w_carry),
`endif
    .o_res    (w_res),
    .o_zero   (w_zero),
    .o_parity (w_parity)
  );

  // Stage 2: registered result, flags and tag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vld_p2    <= 1'b0;
      r_out_p2    <= '0;
      r_zero_p2   <= 1'b0;
      r_parity_p2 <= 1'b0;
      r_tag_p2    <= '0;
`ifdef ALU_CARRY_FLAG_EN
      r_carry_p2  <= 1'b0;
`endif
    end else if (w_s2_load) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_p2    <= w_res;
        r_zero_p2   <= w_zero;
        r_parity_p2 <= w_parity;
        r_tag_p2    <= r_req_p1.tag;
`ifdef ALU_CARRY_FLAG_EN
        r_carry_p2  <= w_carry;
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_vld_p2 && OutReady && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign OutValid   = r_vld_p2;
  assign Out        = r_out_p2;
  assign Zero       = r_zero_p2;
  assign Parity     = r_parity_p2;
  assign OutTag     = r_tag_p2;
  assign RetiredCnt = r_cnt;
`ifdef ALU_CARRY_FLAG_EN
  assign Carry      = r_carry_p2;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized traffic checked
// against a transaction-level queue model (capacity-2 pipe, 2-cycle latency).
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W     = 8;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int MOD   = 1 << W;
  localparam int HALF  = 1 << (W - 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [W-1:0]     InputA = '0;
  logic [W-1:0]     InputB = '0;
  alu_op_e          OP = NOP;
  logic [TAG_W-1:0] InTag = '0;
  logic             OutValid;
  logic             OutReady = 1'b1;
  logic [W-1:0]     Out;
  logic             Zero, Parity;
  logic [TAG_W-1:0] OutTag;
  logic [CNT_W-1:0] RetiredCnt;
`ifdef ALU_CARRY_FLAG_EN
  logic             Carry;
`endif

  alu_pipe #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InputA(InputA), .InputB(InputB), .OP(OP), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out), .Zero(Zero),
    .Parity(Parity), .OutTag(OutTag),
`ifdef ALU_CARRY_FLAG_EN
    .Carry(Carry),
`endif
    .RetiredCnt(RetiredCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int out;
    int tag;
    int carry;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   cnt_mdl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_out(input int a, input int b, input alu_op_e op);
    int lo_a = a % HALF;
    int lo_b = b % HALF;
    case (op)
      ERRFLG:  return (($countones(lo_a) % 2) * HALF) + lo_a;
      SUB:     return (a - b + MOD) % MOD;
      PAR:     return $countones(a & b) % 2;
      ADD:     return (a + b) % MOD;
      XOR:     return lo_a ^ lo_b;
      LSOR:    return ((lo_a * 2) % HALF) | lo_b;
      SHR:     return a >> (b % W);
      default: return 0;
    endcase
  endfunction

  function automatic int ref_carry(input int a, input int b, input alu_op_e op);
    if (op == ADD) return (a + b >= MOD) ? 1 : 0;
    if (op == SUB) return (a < b) ? 1 : 0;
    return 0;
  endfunction

  // One clock: drive at posedge+1, check at posedge+2, then advance the model.
  task automatic cycle(input bit v, input int a, input int b, input alu_op_e op,
                       input int tag, input bit ordy);
    bit   exp_rdy, exp_ov;
    exp_t e;
    InValid  = v;
    InputA   = W'(a);
    InputB   = W'(b);
    OP       = op;
    InTag    = TAG_W'(tag);
    OutReady = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
    check("in_ready", InReady, exp_rdy);
    check("out_valid", OutValid, exp_ov);
    check("retired_cnt", RetiredCnt, cnt_mdl);
    if (exp_ov) begin
      check("out", Out, q[0].out);
      check("out_tag", OutTag, q[0].tag);
      check("zero", Zero, (q[0].out == 0) ? 1 : 0);
      check("parity", Parity, $countones(q[0].out) % 2);
`ifdef ALU_CARRY_FLAG_EN
      check("carry", Carry, q[0].carry);
`endif
    end
    @(posedge Clk);
    #1;
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      if (cnt_mdl < CMAX) cnt_mdl++;
    end
    if (v && exp_rdy) begin
      e.out   = ref_out(a % MOD, b % MOD, op);
      e.tag   = tag % (1 << TAG_W);
      e.carry = ref_carry(a % MOD, b % MOD, op);
      e.cyc   = cyc;
      q.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, NOP, 0, ordy);
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    InValid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    q.delete();
    cnt_mdl = 0;
    check("rst_out_valid", OutValid, 0);
    check("rst_out", Out, 0);
    check("rst_zero", Zero, 0);
    check("rst_parity", Parity, 0);
    check("rst_out_tag", OutTag, 0);
    check("rst_cnt", RetiredCnt, 0);
    check("rst_in_ready", InReady, 1);
`ifdef ALU_CARRY_FLAG_EN
    check("rst_carry", Carry, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    cycle(1'b1, 'hF0, 'h20, ADD, 3, 1'b1);
    idle(3, 1'b1);

    cycle(1'b1, 'h05, 'h05, SUB, 1, 1'b1);
    cycle(1'b1, 'h07, 'h00, ERRFLG, 2, 1'b1);
    cycle(1'b1, 'h40, 'h01, LSOR, 4, 1'b1);
    idle(3, 1'b1);

    cycle(1'b1, 'h12, 'h34, XOR, 5, 1'b0);
    cycle(1'b1, 'h33, 'h0F, PAR, 6, 1'b0);
    cycle(1'b1, 'h01, 'h02, ADD, 7, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    cycle(1'b1, 'h80, 'h0B, SHR, 8, 1'b1);
    cycle(1'b1, 'hAA, 'h55, NOP, 9, 1'b1);
    cycle(1'b1, 'h10, 'h20, SUB, 10, 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 17; i++) cycle(1'b1, i, i * 3, ADD, i, 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 300; i++)
      cycle(($urandom % 4) != 0, $urandom % MOD, $urandom % MOD,
            alu_op_e'($urandom % 8), $urandom % (1 << TAG_W), ($urandom % 4) != 0);
    idle(3, 1'b1);

    cycle(1'b1, 'h11, 'h22, ADD, 11, 1'b1);
    cycle(1'b1, 'h33, 'h44, ADD, 12, 1'b1);
    do_reset();
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
